// File: rtl/apb_slave_regfile.sv
// APB completer: 8 x 32-bit register file (reg0 read-only ID, reg1..reg7 read/write)
// with address decode, programmable wait states, error response and transfer counter.
module apb_slave_regfile #(
    parameter int unsigned SLV_IDX     = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0000
) (
    input  logic        h_clk,
    input  logic        h_reset,
    input  logic [2:0]  p_selx,
    input  logic        p_enable,
    input  logic        p_write,
    input  logic [31:0] p_addr,
    input  logic [31:0] p_wdata,
    output logic [31:0] p_rdata,
    output logic        p_ready,
    output logic        p_slverr,
    output logic [15:0] xfer_cnt,
    output logic        proto_err
);
    localparam logic [3:0]  WAIT_LIM = 4'(WAIT_CYCLES);
    localparam logic [31:0] ID_WORD  = ID_VALUE | {30'd0, 2'(SLV_IDX)};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    state_e      state_q;
    logic [31:0] regs_q [8];
    logic [31:0] rdata_q;
    logic [31:0] lat_wdata_q;
    logic [2:0]  lat_idx_q;
    logic        lat_write_q;
    logic        lat_err_q;
    logic        ready_q;
    logic        slverr_q;
    logic        proto_err_q;
    logic [3:0]  wait_q;
    logic [15:0] xfer_cnt_q;
    logic [15:0] xfer_cnt_d;

    logic        sel_s;
    logic        in_range_s;
    logic        dec_err_s;
    logic        done_s;
    logic [2:0]  idx_s;
    logic [3:0]  wait_inc_s;
    logic [31:0] rdata_d;
    logic        unused_s;

    // Byte-lane bits and foreign select bits carry no meaning for this instance.
    assign unused_s = ^{p_selx, p_addr[1:0]};

    // Address decode and read mux for the transfer currently on the bus.
    always_comb begin
        sel_s      = p_selx[SLV_IDX];
        idx_s      = p_addr[4:2];
        in_range_s = (p_addr[31:5] == BASE_ADDR[31:5]);
        dec_err_s  = !in_range_s || (p_write && (idx_s == 3'd0));
        if (!in_range_s) begin
            rdata_d = 32'd0;
        end else if (idx_s == 3'd0) begin
            rdata_d = ID_WORD;
        end else begin
            rdata_d = regs_q[idx_s];
        end
    end

    // Completion detect, wait-counter increment and transfer counter next state.
    always_comb begin
        done_s     = (state_q == ST_ACCESS) && ready_q;
        wait_inc_s = wait_q + 4'd1;
        if (done_s) begin
            xfer_cnt_d = xfer_cnt_q + 16'd1;
        end else begin
            xfer_cnt_d = xfer_cnt_q;
        end
    end

    // Protocol FSM, register file and registered APB responses.
    always_ff @(posedge h_clk) begin
        if (h_reset) begin
            state_q <= ST_IDLE;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 32'd0;
            end
            rdata_q     <= 32'd0;
            lat_wdata_q <= 32'd0;
            lat_idx_q   <= 3'd0;
            lat_write_q <= 1'b0;
            lat_err_q   <= 1'b0;
            ready_q     <= 1'b0;
            slverr_q    <= 1'b0;
            proto_err_q <= 1'b0;
            wait_q      <= 4'd0;
            xfer_cnt_q  <= 16'd0;
        end else begin
            ready_q    <= 1'b0;
            slverr_q   <= 1'b0;
            xfer_cnt_q <= xfer_cnt_d;
            case (state_q)
                ST_IDLE: begin
                    if (sel_s && !p_enable) begin
                        state_q <= ST_SETUP;
                    end else if (sel_s) begin
                        proto_err_q <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    lat_idx_q   <= idx_s;
                    lat_write_q <= p_write;
                    lat_wdata_q <= p_wdata;
                    lat_err_q   <= dec_err_s;
                    if (!p_write) begin
                        rdata_q <= rdata_d;
                    end else begin
                        rdata_q <= rdata_q;
                    end
                    wait_q   <= 4'd0;
                    ready_q  <= (WAIT_LIM == 4'd0);
                    slverr_q <= (WAIT_LIM == 4'd0) && dec_err_s;
                    state_q  <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (ready_q) begin
                        if (lat_write_q && !lat_err_q) begin
                            regs_q[lat_idx_q] <= lat_wdata_q;
                        end
                        // A new setup phase in the completing cycle chains straight into SETUP.
                        if (sel_s && !p_enable) begin
                            state_q <= ST_SETUP;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else if (!sel_s || !p_enable) begin
                        proto_err_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        wait_q   <= wait_inc_s;
                        ready_q  <= (wait_inc_s == WAIT_LIM);
                        slverr_q <= (wait_inc_s == WAIT_LIM) && lat_err_q;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign p_rdata   = rdata_q;
    assign p_ready   = ready_q;
    assign p_slverr  = slverr_q;
    assign xfer_cnt  = xfer_cnt_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: three instances on one APB bus (different select bits and
// wait states), driven transaction by transaction and compared against a register-array model.
module tb_apb_slave_regfile;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] IDV  = 32'hA5B0_0000;

    logic h_clk = 1'b0;
    logic h_reset;
    logic [2:0]  p_selx;
    logic        p_enable;
    logic        p_write;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;

    logic [2:0][31:0] rdata_o;
    logic [2:0]       ready_o;
    logic [2:0]       slverr_o;
    logic [2:0][15:0] cnt_o;
    logic [2:0]       perr_o;

    int wcyc [3] = '{2, 0, 3};

    apb_slave_regfile #(.SLV_IDX(0), .BASE_ADDR(BASE), .WAIT_CYCLES(2), .ID_VALUE(IDV)) dut0 (
        .h_clk(h_clk), .h_reset(h_reset), .p_selx(p_selx), .p_enable(p_enable),
        .p_write(p_write), .p_addr(p_addr), .p_wdata(p_wdata), .p_rdata(rdata_o[0]),
        .p_ready(ready_o[0]), .p_slverr(slverr_o[0]), .xfer_cnt(cnt_o[0]), .proto_err(perr_o[0]));
    apb_slave_regfile #(.SLV_IDX(1), .BASE_ADDR(BASE), .WAIT_CYCLES(0), .ID_VALUE(IDV)) dut1 (
        .h_clk(h_clk), .h_reset(h_reset), .p_selx(p_selx), .p_enable(p_enable),
        .p_write(p_write), .p_addr(p_addr), .p_wdata(p_wdata), .p_rdata(rdata_o[1]),
        .p_ready(ready_o[1]), .p_slverr(slverr_o[1]), .xfer_cnt(cnt_o[1]), .proto_err(perr_o[1]));
    apb_slave_regfile #(.SLV_IDX(2), .BASE_ADDR(BASE), .WAIT_CYCLES(3), .ID_VALUE(IDV)) dut2 (
        .h_clk(h_clk), .h_reset(h_reset), .p_selx(p_selx), .p_enable(p_enable),
        .p_write(p_write), .p_addr(p_addr), .p_wdata(p_wdata), .p_rdata(rdata_o[2]),
        .p_ready(ready_o[2]), .p_slverr(slverr_o[2]), .xfer_cnt(cnt_o[2]), .proto_err(perr_o[2]));

    always #5 h_clk = ~h_clk;

    // Model: register contents, counters and the responses expected in the current cycle.
    logic [31:0] regs_m  [3][8];
    logic [15:0] cnt_m   [3];
    logic        perr_m  [3];
    logic [31:0] rdata_m [3];
    logic        e_ready [3];
    logic        e_slverr[3];
    logic        pend_v;
    int          pend_k;
    logic        pend_w;
    int          pend_idx;
    logic [31:0] pend_data;

    int   n_chk  = 0;
    int   n_pass = 0;
    logic chk_on = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Per-cycle comparison of every instance against the model.
    always @(negedge h_clk) begin
        if (chk_on) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("ready%0d", k),  {31'd0, ready_o[k]},  {31'd0, e_ready[k]});
                check($sformatf("slverr%0d", k), {31'd0, slverr_o[k]}, {31'd0, e_slverr[k]});
                check($sformatf("rdata%0d", k),  rdata_o[k],           rdata_m[k]);
                check($sformatf("xfer_cnt%0d", k), {16'd0, cnt_o[k]},  {16'd0, cnt_m[k]});
                check($sformatf("proto_err%0d", k), {31'd0, perr_o[k]}, {31'd0, perr_m[k]});
            end
        end
    end

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) regs_m[k][i] = 32'd0;
            cnt_m[k]   = 16'd0;
            perr_m[k]  = 1'b0;
            rdata_m[k] = 32'd0;
        end
        pend_v = 1'b0;
    endtask

    task automatic drive(input logic [2:0] s, input logic en, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        p_selx = s; p_enable = en; p_write = wr; p_addr = a; p_wdata = d;
    endtask

    // Advance one clock and apply whatever the model says happened at that edge.
    task automatic step();
        @(posedge h_clk);
        #2;
        if (h_reset) begin
            model_reset();
        end else if (pend_v) begin
            if (pend_w) regs_m[pend_k][pend_idx] = pend_data;
            cnt_m[pend_k] = cnt_m[pend_k] + 16'd1;
        end
        pend_v = 1'b0;
        for (int k = 0; k < 3; k++) begin
            e_ready[k]  = 1'b0;
            e_slverr[k] = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(3'd0, 1'b0, 1'b0, $urandom, $urandom);
            step();
        end
    endtask

    task automatic reset_all();
        h_reset = 1'b1;
        drive(3'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();
        h_reset = 1'b0;
    endtask

    // Setup phase plus the SETUP-state cycle; returns in the first ACCESS cycle.
    task automatic start(input int k, input logic wr, input logic [31:0] a, input logic [31:0] d,
                         output logic err, output int idx);
        logic [2:0]  s;
        logic [31:0] rv;
        s   = 3'b001 << k;
        idx = int'(a[4:2]);
        err = !((a - BASE) < 32'd32) || (wr && idx == 0);
        drive(s, 1'b0, wr, a, d);
        step();
        drive(s, 1'b1, wr, a, d);
        rv = err ? 32'd0 : ((idx == 0) ? (IDV | 32'(k)) : regs_m[k][idx]);
        step();
        if (!wr) rdata_m[k] = rv;
    endtask

    // Complete transfer; returns in its ready cycle with the completion pending.
    task automatic xfer(input int k, input logic wr, input logic [31:0] a, input logic [31:0] d);
        logic err;
        int   idx;
        start(k, wr, a, d, err, idx);
        for (int n = 0; n < wcyc[k]; n++) begin
            drive(3'b001 << k, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
            step();
        end
        e_ready[k]  = 1'b1;
        e_slverr[k] = err;
        pend_v = 1'b1; pend_k = k; pend_w = wr && !err; pend_idx = idx; pend_data = d;
    endtask

    // Transfer broken off before ready: 0 = select dropped, 1 = enable dropped, 2 = reset.
    task automatic abort_x(input int k, input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input int at, input int mode);
        logic err;
        int   idx;
        start(k, wr, a, d, err, idx);
        for (int n = 0; n < at; n++) begin
            drive(3'b001 << k, 1'b1, wr, a, d);
            step();
        end
        if (mode == 0) drive(3'd0, 1'b0, wr, a, d);
        else if (mode == 1) drive(3'b001 << k, 1'b0, wr, a, d);
        else begin
            h_reset = 1'b1;
            drive(3'b001 << k, 1'b1, wr, a, d);
        end
        step();
        if (mode == 2) h_reset = 1'b0;
        else perr_m[k] = 1'b1;
    endtask

    task automatic viol(input int k);
        drive(3'b001 << k, 1'b1, 1'($urandom_range(0, 1)), BASE, $urandom);
        step();
        perr_m[k] = 1'b1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        if ($urandom_range(0, 9) < 8) a = BASE + 32'($urandom_range(0, 31));
        else if ($urandom_range(0, 1) == 1) a = 32'h9000_0000 + 32'($urandom_range(0, 31));
        else a = $urandom;
        return a;
    endfunction

    initial begin
        h_reset = 1'b1;
        drive(3'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();
        h_reset = 1'b0;
        chk_on  = 1'b1;
        check("rst_rdata", rdata_o[1], 32'd0);
        check("rst_cnt", {16'd0, cnt_o[1]}, 32'd0);
        check("rst_perr", {29'd0, perr_o}, 32'd0);
        check("rst_ready", {29'd0, ready_o}, 32'd0);

        // Read the ID register with no wait states.
        xfer(1, 1'b0, 32'h8000_0000, 32'd0);
        check("t1_ready", {31'd0, ready_o[1]}, 32'd1);
        check("t1_id", rdata_o[1], 32'hA5B0_0001);
        check("t1_slverr", {31'd0, slverr_o[1]}, 32'd0);
        idle(1);
        check("t1_cnt", {16'd0, cnt_o[1]}, 32'd1);

        // Back-to-back write then read of reg3.
        reset_all();
        xfer(1, 1'b1, 32'h8000_000C, 32'hDEAD_BEEF);
        xfer(1, 1'b0, 32'h8000_000C, 32'd0);
        check("t2_rdata", rdata_o[1], 32'hDEAD_BEEF);
        idle(1);
        check("t2_cnt", {16'd0, cnt_o[1]}, 32'd2);

        // Three wait states; an aborted write must not reach the register.
        xfer(2, 1'b1, 32'h8000_0004, 32'h0000_1111);
        check("t3_ready", {31'd0, ready_o[2]}, 32'd1);
        abort_x(2, 1'b1, 32'h8000_0004, 32'h0000_2222, 2, 0);
        xfer(2, 1'b0, 32'h8000_0004, 32'd0);
        check("t3_rdata", rdata_o[2], 32'h0000_1111);
        idle(1);

        // Error responses: write to reg0, read outside the region.
        xfer(1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        check("t4_wr_slverr", {31'd0, slverr_o[1]}, 32'd1);
        xfer(1, 1'b0, 32'h9000_0010, 32'd0);
        check("t4_rd_slverr", {31'd0, slverr_o[1]}, 32'd1);
        check("t4_rd_zero", rdata_o[1], 32'd0);
        xfer(1, 1'b0, 32'h8000_0000, 32'd0);
        check("t4_id_kept", rdata_o[1], 32'hA5B0_0001);
        idle(1);
        check("t4_cnt", {16'd0, cnt_o[1]}, 32'd5);

        // Select dropped mid-ACCESS, sticky proto_err, cleared only by reset.
        abort_x(0, 1'b1, 32'h8000_0008, 32'h1234_5678, 1, 0);
        check("t5_perr", {31'd0, perr_o[0]}, 32'd1);
        idle(3);
        check("t5_perr_sticky", {31'd0, perr_o[0]}, 32'd1);
        check("t5_cnt", {16'd0, cnt_o[0]}, 32'd0);
        xfer(0, 1'b0, 32'h8000_0008, 32'd0);
        check("t5_reg2", rdata_o[0], 32'd0);
        reset_all();
        check("t5_perr_clr", {31'd0, perr_o[0]}, 32'd0);

        // Counter wrap: preload near the top, then four reads of reg3.
        force dut1.xfer_cnt_q = 16'hFFFC;
        cnt_m[1] = 16'hFFFC;
        idle(1);
        release dut1.xfer_cnt_q;
        for (int i = 0; i < 4; i++) xfer(1, 1'b0, 32'h8000_000C, 32'd0);
        idle(1);
        check("t6_wrap", {16'd0, cnt_o[1]}, 32'd0);

        // Randomized traffic across all three instances.
        for (int it = 0; it < 1500; it++) begin
            int k;
            int op;
            k  = int'($urandom_range(0, 2));
            op = int'($urandom_range(0, 99));
            if (op < 60) begin
                xfer(k, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
            end else if (op < 74) begin
                idle(int'($urandom_range(1, 3)));
            end else if (op < 88) begin
                if (wcyc[k] > 0)
                    abort_x(k, 1'($urandom_range(0, 1)), rand_addr(), $urandom,
                            int'($urandom_range(0, wcyc[k] - 1)), int'($urandom_range(0, 1)));
                else
                    xfer(k, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
            end else if (op < 97) begin
                idle(1);
                viol(k);
            end else begin
                if (wcyc[k] > 0)
                    abort_x(k, 1'b1, rand_addr(), $urandom, 0, 2);
                else
                    reset_all();
            end
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
